// File: rtl/ppi_mode1_handshake.sv
// ppi_mode1_handshake
// ----------------------------------------------------------------------------
// Single-port strobed I/O handshake in the style of a PPI mode-1 port.
// DIR selects strobed input (peripheral writes via STB_N, CPU reads DOUT) or
// strobed output (CPU writes PORT_OUT, peripheral takes it via ACK_N).
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_dir             1 = strobed input, 0 = strobed output
//   i_inte            interrupt enable (gates o_intr only)
//   i_cs, i_rd, i_wr  active-low CPU select / read / write, synchronous
//   i_din             CPU write data
//   o_dout            input latch, read by the CPU
//   i_port_in         peripheral data in (input mode)
//   o_port_out        output register to the peripheral
//   o_port_oe         peripheral-side driver enable (~i_dir)
//   i_stb_n           asynchronous peripheral strobe, active-low
//   o_ibf             input buffer full
//   i_ack_n           asynchronous peripheral acknowledge, active-low
//   o_obf_n           output buffer full, active-low
//   o_intr            interrupt request (intr_req AND i_inte)
//   o_ovr             input overrun flag
// ----------------------------------------------------------------------------
module ppi_mode1_handshake #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dir,
  input  logic             i_inte,
  input  logic             i_cs,
  input  logic             i_rd,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  input  logic [WIDTH-1:0] i_port_in,
  output logic [WIDTH-1:0] o_port_out,
  output logic             o_port_oe,
  input  logic             i_stb_n,
  output logic             o_ibf,
  input  logic             i_ack_n,
  output logic             o_obf_n,
  output logic             o_intr,
  output logic             o_ovr
);

  typedef enum logic [1:0] {IN_EMPTY, IN_STROBE, IN_FULL, IN_READ} in_state_t;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_WRITE, OUT_FULL, OUT_ACK} out_state_t;

  in_state_t             r_in_state, w_in_nxt;
  out_state_t            r_out_state, w_out_nxt;
  logic [WIDTH-1:0]      r_dout, w_dout_nxt;
  logic [WIDTH-1:0]      r_port_out, w_port_out_nxt;
  logic                  r_ibf, w_ibf_nxt;
  logic                  r_obf_n, w_obf_n_nxt;
  logic                  r_ovr, w_ovr_nxt;
  logic                  r_intr_req, w_intr_nxt;

  logic [SYNC_STAGES-1:0] r_stb_sync, r_ack_sync, r_flush;
  logic                   r_stb_prev, r_ack_prev;
  logic                   r_stb_arm, r_ack_arm;
  logic                   r_rd_d, r_wr_d, r_dir_d;

  logic w_stb_s, w_ack_s, w_flushed;
  logic w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise;
  logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic w_dir_chg;

  // Synchronized levels and edges of the asynchronous strobes
  assign w_stb_s   = r_stb_sync[SYNC_STAGES-1];
  assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
  assign w_flushed = r_flush[SYNC_STAGES-1];

  // The synchronizers reset to the inactive level, so a line held low
  // through reset would otherwise look like a fresh falling edge. A fall
  // only counts once the synced line has been seen high after reset.
  assign w_stb_fall = r_stb_arm &  r_stb_prev & ~w_stb_s;
  assign w_stb_rise = ~r_stb_prev & w_stb_s;
  assign w_ack_fall = r_ack_arm &  r_ack_prev & ~w_ack_s;
  assign w_ack_rise = ~r_ack_prev & w_ack_s;

  assign w_rd_fall = ~i_cs &  r_rd_d & ~i_rd;
  assign w_rd_rise = ~i_cs & ~r_rd_d &  i_rd;
  assign w_wr_fall = ~i_cs &  r_wr_d & ~i_wr;
  assign w_wr_rise = ~i_cs & ~r_wr_d &  i_wr;

  assign w_dir_chg = i_dir ^ r_dir_d;

  // Stage 0: edge-detection and synchronizer flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stb_sync <= '1;
      r_ack_sync <= '1;
      r_stb_prev <= 1'b1;
      r_ack_prev <= 1'b1;
      r_flush    <= '0;
      r_stb_arm  <= 1'b0;
      r_ack_arm  <= 1'b0;
      r_rd_d     <= 1'b1;
      r_wr_d     <= 1'b1;
      r_dir_d    <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], i_stb_n};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack_n};
      r_stb_prev <= w_stb_s;
      r_ack_prev <= w_ack_s;
      // r_flush fills once the chain holds post-reset samples only
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_stb_arm  <= r_stb_arm | (w_flushed & w_stb_s);
      r_ack_arm  <= r_ack_arm | (w_flushed & w_ack_s);
      r_rd_d     <= i_rd;
      r_wr_d     <= i_wr;
      r_dir_d    <= i_dir;
    end
  end

  // Next-state and flag logic for both handshake FSMs
  always_comb begin
    w_in_nxt       = r_in_state;
    w_out_nxt      = r_out_state;
    w_dout_nxt     = r_dout;
    w_port_out_nxt = r_port_out;
    w_ibf_nxt      = r_ibf;
    w_obf_n_nxt    = r_obf_n;
    w_ovr_nxt      = r_ovr;
    w_intr_nxt     = r_intr_req;

    if (w_dir_chg) begin
      // Mode switch aborts everything but keeps both data registers
      w_in_nxt    = IN_EMPTY;
      w_out_nxt   = OUT_EMPTY;
      w_ibf_nxt   = 1'b0;
      w_ovr_nxt   = 1'b0;
      w_intr_nxt  = 1'b0;
      w_obf_n_nxt = 1'b1;
    end else if (i_dir) begin
      w_out_nxt = OUT_EMPTY;
      case (r_in_state)
        IN_EMPTY: begin
          if (w_stb_fall) begin
            w_dout_nxt = i_port_in;
            w_ibf_nxt  = 1'b1;
            w_in_nxt   = IN_STROBE;
          end
        end
        IN_STROBE: begin
          if (w_stb_rise) begin
            w_in_nxt   = IN_FULL;
            w_intr_nxt = 1'b1;
          end
        end
        IN_FULL: begin
          if (w_rd_fall) begin
            w_in_nxt   = IN_READ;
            w_intr_nxt = 1'b0;
          end
          if (w_stb_fall) w_ovr_nxt = 1'b1;
        end
        IN_READ: begin
          // A strobe landing on the read-completion edge is dropped
          if (w_rd_rise) begin
            w_in_nxt  = IN_EMPTY;
            w_ibf_nxt = 1'b0;
            w_ovr_nxt = 1'b0;
          end else if (w_stb_fall) begin
            w_ovr_nxt = 1'b1;
          end
        end
        default: w_in_nxt = IN_EMPTY;
      endcase
    end else begin
      w_in_nxt = IN_EMPTY;
      case (r_out_state)
        OUT_EMPTY, OUT_FULL: begin
          // CPU write wins over a coincident acknowledge
          if (w_wr_fall) begin
            w_out_nxt      = OUT_WRITE;
            w_port_out_nxt = i_din;
            w_intr_nxt     = 1'b0;
            w_obf_n_nxt    = 1'b1;
          end else if ((r_out_state == OUT_FULL) && w_ack_fall) begin
            w_out_nxt   = OUT_ACK;
            w_obf_n_nxt = 1'b1;
          end
        end
        OUT_WRITE: begin
          if (w_wr_rise) begin
            w_out_nxt   = OUT_FULL;
            w_obf_n_nxt = 1'b0;
          end
        end
        OUT_ACK: begin
          if (w_ack_rise) begin
            w_out_nxt  = OUT_EMPTY;
            w_intr_nxt = 1'b1;
          end
        end
        default: w_out_nxt = OUT_EMPTY;
      endcase
    end
  end

  // Stage 1: FSM state, flags and data registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_state  <= IN_EMPTY;
      r_out_state <= OUT_EMPTY;
      r_dout      <= '0;
      r_port_out  <= '0;
      r_ibf       <= 1'b0;
      r_obf_n     <= 1'b1;
      r_ovr       <= 1'b0;
      r_intr_req  <= 1'b0;
    end else begin
      r_in_state  <= w_in_nxt;
      r_out_state <= w_out_nxt;
      r_dout      <= w_dout_nxt;
      r_port_out  <= w_port_out_nxt;
      r_ibf       <= w_ibf_nxt;
      r_obf_n     <= w_obf_n_nxt;
      r_ovr       <= w_ovr_nxt;
      r_intr_req  <= w_intr_nxt;
    end
  end

  assign o_dout     = r_dout;
  assign o_port_out = r_port_out;
  assign o_port_oe  = ~i_dir;
  assign o_ibf      = r_ibf;
  assign o_obf_n    = r_obf_n;
  assign o_ovr      = r_ovr;
  assign o_intr     = r_intr_req & i_inte;

endmodule

// File: tb/tb_ppi_mode1_handshake.sv
module tb_ppi_mode1_handshake;

  logic       clk = 1'b0;
  logic       rst, dir, inte, cs, rd, wr, stb_n, ack_n;
  logic [7:0] din, port_in;
  logic [7:0] dout, port_out;
  logic       port_oe, ibf, obf_n, intr, ovr;

  int checks = 0;
  int errors = 0;

  ppi_mode1_handshake #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_dir(dir), .i_inte(inte),
    .i_cs(cs), .i_rd(rd), .i_wr(wr), .i_din(din), .o_dout(dout),
    .i_port_in(port_in), .o_port_out(port_out), .o_port_oe(port_oe),
    .i_stb_n(stb_n), .o_ibf(ibf), .i_ack_n(ack_n), .o_obf_n(obf_n),
    .o_intr(intr), .o_ovr(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input int w);
    port_in = d;
    stb_n   = 1'b0;
    cyc(w);
    stb_n   = 1'b1;
    cyc(4);
  endtask

  task automatic cpu_read();
    cs = 1'b0; rd = 1'b0;
    cyc(1);
    rd = 1'b1;
    cyc(1);
    cs = 1'b1;
    cyc(1);
  endtask

  // Output-mode table: one record per clock
  typedef struct {
    logic       inte;
    logic       cs;
    logic       wr;
    logic       ack_n;
    logic [7:0] din;
    logic [7:0] e_pout;
    logic       e_obf_n;
    logic       e_intr;
  } vec_t;

  vec_t tbl[42];

  // Transaction-level reference state for the randomized phases
  logic [7:0] m_dout, m_pout;
  logic       m_full, m_ovr, m_intr, m_obf;

  initial begin
    //            inte cs   wr   ack  din    pout   obf_n intr
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,8'h5A,8'h5A,1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b1,8'h5A,8'h5A,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h5A,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h5A,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h5A,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h5A,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h5A,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h5A,1'b1,1'b1};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,8'h00,8'h5A,1'b1,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h5A,1'b1,1'b1};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b1,8'hFF,8'h5A,1'b1,1'b1};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,8'hFF,8'h5A,1'b1,1'b1};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b1,8'hC3,8'hC3,1'b1,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b1,1'b1,8'hC3,8'hC3,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b0,1'b0};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b0,1'b0};
    tbl[17] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b0};
    tbl[18] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b0};
    tbl[19] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b0};
    tbl[20] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b1};
    // acknowledge while empty is ignored
    tbl[21] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[22] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[23] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[24] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[25] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b1};
    tbl[26] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b1};
    tbl[27] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'hC3,1'b1,1'b1};
    // WR fall coincides with the synced ACK fall: write wins
    tbl[28] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[29] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'hC3,1'b1,1'b1};
    tbl[30] = '{1'b1,1'b0,1'b0,1'b0,8'h96,8'h96,1'b1,1'b0};
    tbl[31] = '{1'b1,1'b0,1'b1,1'b0,8'h96,8'h96,1'b0,1'b0};
    tbl[32] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h96,1'b0,1'b0};
    tbl[33] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b0,1'b0};
    tbl[34] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b0,1'b0};
    tbl[35] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b0,1'b0};
    tbl[36] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h96,1'b0,1'b0};
    tbl[37] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h96,1'b0,1'b0};
    tbl[38] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h96,1'b1,1'b0};
    tbl[39] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b1,1'b0};
    tbl[40] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b1,1'b0};
    tbl[41] = '{1'b1,1'b1,1'b1,1'b1,8'h00,8'h96,1'b1,1'b1};

    rst = 1'b1; dir = 1'b1; inte = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1;
    din = 8'h00; port_in = 8'h00; stb_n = 1'b1; ack_n = 1'b1;
    cyc(2);
    chk8("rst_dout", dout, 8'h00);
    chk8("rst_port_out", port_out, 8'h00);
    chk1("rst_ibf", ibf, 1'b0);
    chk1("rst_obf_n", obf_n, 1'b1);
    chk1("rst_intr", intr, 1'b0);
    chk1("rst_ovr", ovr, 1'b0);
    chk1("rst_oe", port_oe, 1'b0);
    rst = 1'b0;
    cyc(5);

    // Basic strobed input with exact synchronizer latency
    port_in = 8'hA5;
    stb_n   = 1'b0;
    cyc(2);
    chk1("in_ibf_k1", ibf, 1'b0);
    cyc(1);
    chk1("in_ibf_k2", ibf, 1'b1);
    chk8("in_dout", dout, 8'hA5);
    port_in = 8'h00;
    stb_n   = 1'b1;
    cyc(2);
    chk1("in_intr_early", intr, 1'b0);
    cyc(1);
    chk1("in_intr_set", intr, 1'b1);
    cs = 1'b0; rd = 1'b0;
    cyc(1);
    chk1("rd_fall_intr", intr, 1'b0);
    chk1("rd_fall_ibf", ibf, 1'b1);
    rd = 1'b1;
    cyc(1);
    chk1("rd_rise_ibf", ibf, 1'b0);
    cs = 1'b1;
    cyc(1);

    // Overrun: second strobe before read keeps the first byte
    strobe(8'hA5, 3);
    chk1("ovr_ibf1", ibf, 1'b1);
    chk1("ovr_pre", ovr, 1'b0);
    strobe(8'h3C, 3);
    chk8("ovr_dout", dout, 8'hA5);
    chk1("ovr_set", ovr, 1'b1);
    cpu_read();
    chk1("ovr_clr", ovr, 1'b0);
    chk1("ovr_ibf0", ibf, 1'b0);

    // Interrupt enable gating
    inte = 1'b0;
    strobe(8'h77, 4);
    chk1("inte0_intr", intr, 1'b0);
    chk1("inte0_ibf", ibf, 1'b1);
    inte = 1'b1;
    #1;
    chk1("inte1_intr", intr, 1'b1);
    inte = 1'b0;
    #1;
    chk1("inte_off_again", intr, 1'b0);
    inte = 1'b1;
    #1;
    chk1("inte_req_kept", intr, 1'b1);
    cpu_read();

    // RD rise coincident with synced STB fall: strobe dropped
    strobe(8'h11, 3);
    cs = 1'b0; rd = 1'b0;
    cyc(1);
    port_in = 8'h22;
    stb_n   = 1'b0;
    cyc(2);
    rd = 1'b1;
    cyc(1);
    cs = 1'b1;
    chk1("coinc_ibf", ibf, 1'b0);
    chk1("coinc_ovr", ovr, 1'b0);
    cyc(2);
    chk1("coinc_ibf_hold", ibf, 1'b0);
    chk8("coinc_dout", dout, 8'h11);
    stb_n = 1'b1;
    cyc(4);

    // Reset mid-handshake with STB_N held low
    port_in = 8'h9C;
    stb_n   = 1'b0;
    cyc(4);
    chk1("mid_ibf", ibf, 1'b1);
    rst = 1'b1;
    #2;
    chk1("async_rst_ibf", ibf, 1'b0);
    chk8("async_rst_dout", dout, 8'h00);
    cyc(2);
    rst = 1'b0;
    port_in = 8'h44;
    cyc(6);
    chk1("post_rst_no_latch", ibf, 1'b0);
    chk8("post_rst_dout", dout, 8'h00);
    stb_n = 1'b1;
    cyc(4);
    chk1("post_rst_rise", ibf, 1'b0);
    stb_n = 1'b0;
    cyc(4);
    chk1("post_rst_fall", ibf, 1'b1);
    chk8("post_rst_relatch", dout, 8'h44);
    stb_n = 1'b1;
    cyc(4);
    cpu_read();

    // Direction changes
    dir = 1'b0;
    cyc(4);
    chk1("oe_out_mode", port_oe, 1'b1);
    cs = 1'b0; wr = 1'b0; din = 8'hE7;
    cyc(1);
    wr = 1'b1;
    cyc(1);
    cs = 1'b1;
    chk1("dir_obf_full", obf_n, 1'b0);
    chk8("dir_pout", port_out, 8'hE7);
    dir = 1'b1;
    cyc(1);
    chk1("dir_obf_clr", obf_n, 1'b1);
    chk1("dir_intr_clr", intr, 1'b0);
    chk8("dir_pout_kept", port_out, 8'hE7);
    chk1("dir_oe", port_oe, 1'b0);
    chk8("dir_dout_kept", dout, 8'h44);
    strobe(8'h66, 3);
    chk1("dir_in_intr", intr, 1'b1);
    dir = 1'b0;
    cyc(1);
    chk1("dir_ibf_clr", ibf, 1'b0);
    chk1("dir_intr_clr2", intr, 1'b0);
    chk8("dir_dout_kept2", dout, 8'h66);
    cyc(3);

    // Output-mode table
    for (int i = 0; i < 42; i++) begin
      inte  = tbl[i].inte;
      cs    = tbl[i].cs;
      wr    = tbl[i].wr;
      ack_n = tbl[i].ack_n;
      din   = tbl[i].din;
      cyc(1);
      chk8($sformatf("tbl%0d_pout", i), port_out, tbl[i].e_pout);
      chk1($sformatf("tbl%0d_obf_n", i), obf_n, tbl[i].e_obf_n);
      chk1($sformatf("tbl%0d_intr", i), intr, tbl[i].e_intr);
      chk1($sformatf("tbl%0d_oe", i), port_oe, 1'b1);
    end
    cs = 1'b1; wr = 1'b1; ack_n = 1'b1; inte = 1'b1;
    cyc(2);

    // Randomized output transactions
    m_pout = 8'h96; m_obf = 1'b0; m_intr = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      inte = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        d  = 8'($urandom);
        cs = 1'b0; wr = 1'b0; din = d;
        cyc(1 + $urandom_range(0, 2));
        wr = 1'b1;
        cyc(1);
        cs = 1'b1;
        cyc(1);
        m_pout = d; m_obf = 1'b1; m_intr = 1'b0;
      end else begin
        ack_n = 1'b0;
        cyc($urandom_range(3, 5));
        ack_n = 1'b1;
        cyc(4);
        if (m_obf) begin
          m_obf = 1'b0; m_intr = 1'b1;
        end
      end
      chk8($sformatf("rout%0d_pout", n), port_out, m_pout);
      chk1($sformatf("rout%0d_obf_n", n), obf_n, ~m_obf);
      chk1($sformatf("rout%0d_intr", n), intr, m_intr & inte);
    end

    // Randomized input transactions
    dir = 1'b1;
    cyc(2);
    m_dout = 8'h66; m_full = 1'b0; m_ovr = 1'b0; m_intr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      inte = 1'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        d = 8'($urandom);
        strobe(d, $urandom_range(3, 5));
        if (!m_full) begin
          m_dout = d; m_full = 1'b1; m_intr = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        cpu_read();
        if (m_full) begin
          m_full = 1'b0; m_ovr = 1'b0; m_intr = 1'b0;
        end
      end
      chk8($sformatf("rin%0d_dout", n), dout, m_dout);
      chk1($sformatf("rin%0d_ibf", n), ibf, m_full);
      chk1($sformatf("rin%0d_ovr", n), ovr, m_ovr);
      chk1($sformatf("rin%0d_intr", n), intr, m_intr & inte);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppi_mode1_handshake.md
PPI_MODE1_HANDSHAKE -- requirements
Module: ppi_mode1_handshake

Interface
REQ-001 Parameter WIDTH, default 8: port and data width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on STB_N and ACK_N (minimum 2).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 DIR  input  1  1 = strobed input, 0 = strobed output.
REQ-006 INTE  input  1  interrupt enable.
REQ-007 CS, RD, WR  input  1 each  active-low CPU select/read/write, synchronous to CLK.
REQ-008 DIN  input  WIDTH  CPU write data.
REQ-009 DOUT  output  WIDTH  CPU read data (input latch).
REQ-010 PORT_IN  input  WIDTH  peripheral data, input mode.
REQ-011 PORT_OUT  output  WIDTH  output register to peripheral.
REQ-012 PORT_OE  output  1  equals ~DIR; peripheral-side driver enable.
REQ-013 STB_N  input  1  async peripheral strobe, active-low, input mode.
REQ-014 IBF  output  1  input buffer full.
REQ-015 ACK_N  input  1  async peripheral acknowledge, active-low, output mode.
REQ-016 OBF_N  output  1  output buffer full, active-low.
REQ-017 INTR  output  1  interrupt request to CPU.
REQ-018 OVR  output  1  input overrun flag.

Function
REQ-019 STB_N and ACK_N SHALL pass through SYNC_STAGES flops plus one edge-detect flop; with SYNC_STAGES=2, a falling edge first sampled on CLK edge k is acted on at edge k+2.
REQ-020 RD and WR edges SHALL be detected by a one-cycle delayed copy; an edge counts only when CS=0 in the same cycle.
REQ-021 Input FSM states: IN_EMPTY, IN_STROBE (STB_N low), IN_FULL, IN_READ (RD low).
REQ-022 IN_EMPTY to IN_STROBE on synced STB_N fall: latch PORT_IN into DOUT, set IBF=1 in the same edge.
REQ-023 IN_STROBE to IN_FULL on synced STB_N rise: set intr_req=1.
REQ-024 IN_FULL to IN_READ on RD fall: clear intr_req.
REQ-025 IN_READ to IN_EMPTY on RD rise: clear IBF and OVR.
REQ-026 STB_N fall while IBF=1 SHALL NOT overwrite DOUT; set OVR=1 instead and keep the current state.
REQ-027 Output FSM states: OUT_EMPTY, OUT_WRITE (WR low), OUT_FULL, OUT_ACK (ACK_N low).
REQ-028 OUT_EMPTY or OUT_FULL to OUT_WRITE on WR fall: load DIN into PORT_OUT, clear intr_req.
REQ-029 OUT_WRITE to OUT_FULL on WR rise: OBF_N=0.
REQ-030 OUT_FULL to OUT_ACK on synced ACK_N fall: OBF_N=1.
REQ-031 OUT_ACK to OUT_EMPTY on synced ACK_N rise: intr_req=1.
REQ-032 ACK_N fall in OUT_EMPTY or OUT_WRITE SHALL be ignored; no flag changes.
REQ-033 A WR fall and an ACK_N fall in the same cycle SHALL give priority to WR: PORT_OUT loads, OBF_N stays 1 until WR rise.
REQ-034 An RD rise and an STB_N fall in the same cycle SHALL clear IBF and go to IN_EMPTY; the strobe is dropped and OVR stays 0.
REQ-035 INTR = intr_req AND INTE, combinational; toggling INTE SHALL NOT alter intr_req.
REQ-036 A DIR change (detected by registered copy) SHALL, on the next edge, force the new mode's empty state, clear IBF, OVR and intr_req, set OBF_N=1, and retain DOUT and PORT_OUT.
REQ-037 The FSM not selected by DIR SHALL hold its empty state.

Reset
REQ-038 RST=1 SHALL immediately force DOUT=0, PORT_OUT=0, IBF=0, OBF_N=1, INTR=0, OVR=0, both FSMs empty, and all synchronizer/edge flops to 1 (inactive).
REQ-039 RST asserted mid-handshake SHALL abort it; after release, the first edge to act on is a new falling edge, never a level already low.

Verification
REQ-040 DIR=1, INTE=1, PORT_IN=0xA5, STB_N pulse 3 cycles -> IBF=1 at edge k+2, DOUT=0xA5, INTR=1 after STB_N rise sync; RD pulse -> INTR=0 at RD fall, IBF=0 at RD rise.
REQ-041 DIR=1, second STB_N pulse with PORT_IN=0x3C before read -> DOUT stays 0xA5, OVR=1; read -> OVR=0.
REQ-042 DIR=0, INTE=1, write DIN=0x5A -> PORT_OUT=0x5A at WR fall, OBF_N=0 at WR rise; ACK_N pulse -> OBF_N=1 at synced fall, INTR=1 at synced rise; next WR fall -> INTR=0.
REQ-043 INTE=0 through a full input handshake -> INTR stays 0; raise INTE before read -> INTR=1 immediately.
REQ-044 Assert RST while IBF=1 and STB_N held low; release -> IBF=0, no relatch until STB_N rises and falls again.
REQ-045 Flip DIR while OBF_N=0 -> next edge OBF_N=1, INTR=0, PORT_OUT retained, PORT_OE=0.
